viq: RTL and testbench

VIQ -- requirements
Module: viq

---
 rtl/cellrv32_package.sv | 21 ++
 rtl/viq.sv | 115 +++++++++++
 tb/tb_viq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cellrv32_package.sv
// Shared types for the cellrv32 vector front end.
// remapped_v_instr is the instruction record produced by the register remapper
// and consumed by the vector issue stage. The opcode constants below are the
// major opcodes that the vector pipeline recognises.
package cellrv32_package;

    localparam logic [6:0] OPC_VECTOR = 7'b1010111;  // OP-V arithmetic / vsetvl
    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;  // vector load
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;  // vector store

    typedef struct packed {
        logic       reconfigure;  // vsetvl-type: changes vector configuration
        logic [6:0] opcode;
        logic [5:0] funct6;
        logic [2:0] funct3;
        logic [4:0] dst;
        logic [4:0] src1;
        logic [4:0] src2;
    } remapped_v_instr;

endpackage

// File: rtl/viq.sv
// viq -- vector instruction queue between the register remapper and the
// vector issue stage.
//
// A DEPTH-entry in-order FIFO. A queued reconfigure instruction blocks further
// intake until it has been popped, so the issue stage never sees instructions
// that were remapped under a stale vector configuration behind it.
//
// Ports
//   clk_i        sole clock, rising edge
//   reset        synchronous, active-high reset (priority over everything)
//   flush_i      discard all queued entries
//   valid_in     remapper offers instr_in
//   instr_in     instruction to enqueue
//   ready_o      queue accepts instr_in this cycle
//   valid_o      head entry valid toward issue stage
//   instr_o      head entry (from storage)
//   ready_i      issue stage pops head this cycle
//   count_o      number of occupied entries
//   is_empty_o   count_o == 0
//   rcfg_hold_o  a reconfigure instruction is queued; intake blocked
module viq
    import cellrv32_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   valid_in,
    input  remapped_v_instr        instr_in,
    output logic                   ready_o,
    output logic                   valid_o,
    output remapped_v_instr        instr_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   is_empty_o,
    output logic                   rcfg_hold_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    remapped_v_instr mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          hold_q,   hold_d;
    logic          push, pop;

    // Readiness looks only at the registered count, so a pop in the same
    // cycle never makes room for a push when the queue is full.
    assign ready_o     = (count_q < FULL) & ~hold_q & ~flush_i;
    assign valid_o     = (count_q != '0);
    assign instr_o     = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign is_empty_o  = (count_q == '0);
    assign rcfg_hold_o = hold_q;

    assign push = valid_in & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;

        if (flush_i) begin
            // ready_o is already low, so no push can slip in here.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hold_d   = 1'b0;
        end else begin
            // DEPTH is a power of two, so the natural pointer overflow wraps.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // While holding, the reconfigure entry is the youngest one queued,
            // and a push cannot coincide with its pop.
            if (push && instr_in.reconfigure)
                hold_d = 1'b1;
            else if (pop && instr_o.reconfigure)
                hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= instr_in;
    end

endmodule

// File: tb/tb_viq.sv
module tb_viq;
    import cellrv32_package::*;

    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            valid_in;
    remapped_v_instr instr_in;
    logic            ready_o;
    logic            valid_o;
    remapped_v_instr instr_o;
    logic            ready_i;
    logic [2:0]      count_o;
    logic            is_empty_o;
    logic            rcfg_hold_o;

    viq #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .flush_i     (flush_i),
        .valid_in    (valid_in),
        .instr_in    (instr_in),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .instr_o     (instr_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .is_empty_o  (is_empty_o),
        .rcfg_hold_o (rcfg_hold_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the queue contents themselves.
    remapped_v_instr mq[$];

    function automatic bit m_hold();
        foreach (mq[i]) if (mq[i].reconfigure) return 1'b1;
        return 1'b0;
    endfunction

    function automatic remapped_v_instr mk(input int dst, input bit rc);
        remapped_v_instr r;
        r.reconfigure = rc;
        r.opcode      = rc ? OPC_VECTOR : ($urandom_range(0, 1) ? OPC_VLOAD : OPC_VECTOR);
        r.funct6      = 6'($urandom);
        r.funct3      = rc ? 3'b111 : 3'($urandom);
        r.dst         = 5'(dst);
        r.src1        = 5'($urandom);
        r.src2        = 5'($urandom);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input bit v, input remapped_v_instr ins, input bit rdy,
                         input bit fl, input bit rst, output bit pushed);
        bit exp_ready, exp_valid, pop;
        valid_in = v; instr_in = ins; ready_i = rdy; flush_i = fl; reset = rst;
        #4;
        exp_ready = (mq.size() < DEPTH) && !m_hold() && !fl;
        exp_valid = (mq.size() != 0);
        chk("ready_o",     64'(ready_o),     64'(exp_ready));
        chk("valid_o",     64'(valid_o),     64'(exp_valid));
        chk("count_o",     64'(count_o),     64'(mq.size()));
        chk("is_empty_o",  64'(is_empty_o),  64'(mq.size() == 0));
        chk("rcfg_hold_o", 64'(rcfg_hold_o), 64'(m_hold()));
        if (exp_valid) chk("instr_o", 64'(instr_o), 64'(mq[0]));
        pushed = v && exp_ready && !rst;
        pop    = exp_valid && rdy;
        @(posedge clk_i);
        if (rst || fl) begin
            mq.delete();
            pushed = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (pushed) mq.push_back(ins);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        remapped_v_instr a, r, b, nul;
        bit pushed;
        int guard;
        nul = '0;

        // Initial reset: model is unknown before it, so no checks.
        valid_in = 0; instr_in = '0; ready_i = 0; flush_i = 0; reset = 1;
        @(posedge clk_i); #1;
        mq.delete();
        reset = 0;

        // Reset state
        cycle(0, nul, 0, 0, 0, pushed);

        // Fill with dst 1..4 while stalled, then offer a fifth while full
        for (int i = 1; i <= 4; i++) cycle(1, mk(i, 0), 0, 0, 0, pushed);
        cycle(1, mk(9, 0), 0, 0, 0, pushed);
        chk("full_no_push", 64'(pushed), 64'(0));
        // Full, offering and popping: one pop, no push
        cycle(1, mk(10, 0), 1, 0, 0, pushed);
        chk("full_pop_no_pass", 64'(pushed), 64'(0));
        for (int i = 0; i < 4; i++) cycle(0, nul, 1, 0, 0, pushed);
        cycle(0, nul, 0, 0, 0, pushed);

        // A, reconfigure R, then B offered: B waits for R to leave
        a = mk(11, 0); r = mk(12, 1); b = mk(13, 0);
        cycle(1, a, 0, 0, 0, pushed);
        cycle(1, r, 0, 0, 0, pushed);
        cycle(1, b, 0, 0, 0, pushed);
        chk("blocked_by_rcfg", 64'(pushed), 64'(0));
        guard = 0;
        do begin
            cycle(1, b, 1, 0, 0, pushed);
            guard++;
        end while (!pushed && guard < 10);
        chk("b_accepted_after", 64'(guard), 64'(3));
        for (int i = 0; i < 2; i++) cycle(0, nul, 1, 0, 0, pushed);

        // count=3 with hold set, flush with valid_in high
        cycle(1, mk(1, 0), 0, 0, 0, pushed);
        cycle(1, mk(2, 0), 0, 0, 0, pushed);
        cycle(1, mk(3, 1), 0, 0, 0, pushed);
        cycle(1, mk(4, 0), 0, 1, 0, pushed);
        chk("flush_no_push", 64'(pushed), 64'(0));
        cycle(0, nul, 0, 0, 0, pushed);

        // Streaming dst 0..12 through with count held at 1
        cycle(1, mk(0, 0), 1, 0, 0, pushed);
        for (int i = 1; i <= 12; i++) cycle(1, mk(i, 0), 1, 0, 0, pushed);
        cycle(0, nul, 1, 0, 0, pushed);
        cycle(0, nul, 0, 0, 0, pushed);

        // Reset mid-operation with count=2
        cycle(1, mk(20, 0), 0, 0, 0, pushed);
        cycle(1, mk(21, 0), 0, 0, 0, pushed);
        cycle(1, mk(22, 0), 1, 0, 1, pushed);
        cycle(1, mk(23, 0), 1, 0, 0, pushed);
        cycle(0, nul, 1, 0, 0, pushed);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0),
                  mk($urandom_range(0, 31), $urandom_range(0, 7) == 0),
                  bit'($urandom_range(0, 2) != 0),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 79) == 0,
                  pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
